// File: rtl/core_pkg.sv
// Shared core definitions: base opcodes that carry an immediate, and immediate format codes.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package core_pkg;

   // Base opcodes (instr[6:0]) whose encodings carry an immediate
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;

   // Immediate format code as presented on immType
   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV64I immediate decode: opcode -> format, then field assembly and sign extension.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows instr continuously.
//   instr    in   32  instruction word
//   imm_type out  3   format code (imm_type_e encoding)
//   imm      out  64  sign-extended immediate, zero when the opcode carries none
module imm_decode
   import core_pkg::*;
(
   input  logic [31:0] instr,
   output logic [2:0]  imm_type,
   output logic [63:0] imm
);

   logic sgn;
   assign sgn = instr[31];

   // Only the opcode selects the format; funct3/rd/rs1/rs2 never matter here.
   // Shift immediates fall out as ordinary I immediates; the ALU picks shamt.
   always_comb begin
      imm_type = IMM_NONE;
      imm      = 64'h0;
      case (instr[6:0])
         OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR: begin
            imm_type = IMM_I;
            imm      = {{52{sgn}}, instr[31:20]};
         end
         OPC_STORE: begin
            imm_type = IMM_S;
            imm      = {{52{sgn}}, instr[31:25], instr[11:7]};
         end
         OPC_BRANCH: begin
            imm_type = IMM_B;
            imm      = {{51{sgn}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            // Upper 32 bits replicate bit 31 so RV64 sees a sign-extended 32-bit value
            imm_type = IMM_U;
            imm      = {{32{sgn}}, instr[31:12], 12'h000};
         end
         OPC_JAL: begin
            imm_type = IMM_J;
            imm      = {{43{sgn}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         default: begin
            imm_type = IMM_NONE;
            imm      = 64'h0;
         end
      endcase
   end

endmodule

// File: rtl/immediate_generator.sv
// RV64I immediate generator: decodes the instruction format and registers the sign-extended immediate.
// Latency: 1 cycle; instructor sampled at edge N is visible on the outputs after edge N.
// Backpressure: none; a new instruction is accepted every cycle with no handshake.
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset, clears both outputs
//   instructor in   32  instruction word
//   outputData out  64  registered sign-extended immediate
//   immType    out  3   registered format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
module immediate_generator
   import core_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instructor,
   output logic [XLEN-1:0] outputData,
   output logic [2:0]      immType
);

   logic [2:0]      dec_type;
   logic [XLEN-1:0] dec_imm;

   imm_decode u_imm_decode (
      .instr    (instructor),
      .imm_type (dec_type),
      .imm      (dec_imm)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outputData <= '0;
         immType    <= IMM_NONE;
      end else begin
         outputData <= dec_imm;
         immType    <= dec_type;
      end
   end

endmodule

// File: tb/tb_immediate_generator.sv
module tb_immediate_generator;

   logic        clk;
   logic        rst;
   logic [31:0] instructor;
   logic [63:0] outputData;
   logic [2:0]  immType;

   int checks = 0;
   int errors = 0;

   immediate_generator #(.XLEN(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .instructor (instructor),
      .outputData (outputData),
      .immType    (immType)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [63:0] exp_data;
      logic [2:0]  exp_type;
   } vec_t;

   typedef struct {
      string       name;
      logic [63:0] exp_data;
      logic [2:0]  exp_type;
   } sb_t;

   sb_t  sb[$];
   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] got_d, input logic [2:0] got_t,
                        input logic [63:0] exp_d, input logic [2:0] exp_t);
      checks++;
      if (got_d !== exp_d || got_t !== exp_t) begin
         errors++;
         $display("FAIL %s: got data=%h type=%0d, expected data=%h type=%0d",
                  name, got_d, got_t, exp_d, exp_t);
      end
   endtask

   // Drive at the falling edge and record the expectation.
   task automatic drive(input vec_t v);
      sb_t e;
      @(negedge clk);
      instructor = v.instr;
      e.name     = v.name;
      e.exp_data = v.exp_data;
      e.exp_type = v.exp_type;
      sb.push_back(e);
   endtask

   // Sample just after the rising edge and compare against the oldest expectation.
   task automatic sample();
      sb_t e;
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: output produced with no expectation queued");
      end else begin
         checks--;
         e = sb.pop_front();
         check(e.name, outputData, immType, e.exp_data, e.exp_type);
      end
   endtask

   initial begin
      vecs.push_back('{"zero_none",  32'h0000_0000, 64'h0000_0000_0000_0000, 3'd0});
      vecs.push_back('{"addi_m1",    32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1});
      vecs.push_back('{"sw_m4",      32'hFE11_2E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2});
      vecs.push_back('{"beq_m8",     32'hFE00_0CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3});
      vecs.push_back('{"lui_neg",    32'h8000_00B7, 64'hFFFF_FFFF_8000_0000, 3'd4});
      vecs.push_back('{"jal_2048",   32'h0010_006F, 64'h0000_0000_0000_0800, 3'd5});
      vecs.push_back('{"lw_8",       32'h0081_2283, 64'h0000_0000_0000_0008, 3'd1});
      vecs.push_back('{"addiw_max",  32'h7FF0_809B, 64'h0000_0000_0000_07FF, 3'd1});
      vecs.push_back('{"jalr_0",     32'h0000_8067, 64'h0000_0000_0000_0000, 3'd1});
      vecs.push_back('{"srai_5",     32'h4051_5093, 64'h0000_0000_0000_0405, 3'd1});
      vecs.push_back('{"auipc_pos",  32'h1234_5097, 64'h0000_0000_1234_5000, 3'd4});
      vecs.push_back('{"sd_max",     32'h7E00_3FA3, 64'h0000_0000_0000_07FF, 3'd2});
      vecs.push_back('{"br_max",     32'h7E00_0FE3, 64'h0000_0000_0000_0FFE, 3'd3});
      vecs.push_back('{"jal_m2",     32'hFFFF_F06F, 64'hFFFF_FFFF_FFFF_FFFE, 3'd5});
      vecs.push_back('{"system",     32'hFFFF_FFF3, 64'h0000_0000_0000_0000, 3'd0});
      vecs.push_back('{"op_add",     32'h0020_81B3, 64'h0000_0000_0000_0000, 3'd0});
      vecs.push_back('{"fence",      32'h0FF0_000F, 64'h0000_0000_0000_0000, 3'd0});
      vecs.push_back('{"opc_7f",     32'hFFFF_FFFF, 64'h0000_0000_0000_0000, 3'd0});
      vecs.push_back('{"lui_pos",    32'h7FFF_F0B7, 64'h0000_0000_7FFF_F000, 3'd4});

      // Reset with a nonzero instruction present: outputs must stay cleared across edges.
      rst        = 1'b1;
      instructor = 32'hFFF0_0093;
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", outputData, immType, 64'h0, 3'd0);

      // First post-reset edge loads the instruction already present.
      @(negedge clk);
      rst = 1'b0;
      sb.push_back('{"first_after_reset", 64'hFFFF_FFFF_FFFF_FFFF, 3'd1});
      sample();

      // Back-to-back vectors on consecutive edges; drive and sample overlap in time.
      fork
         begin
            foreach (vecs[i]) drive(vecs[i]);
         end
         begin
            for (int k = 0; k < vecs.size(); k++) sample();
         end
      join

      // Asynchronous reset mid-cycle clears outputs before any clock edge.
      drive('{"pre_async_rst", 32'hFE00_0CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3});
      sample();
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_clear", outputData, immType, 64'h0, 3'd0);
      @(posedge clk);
      #1;
      check("async_rst_hold", outputData, immType, 64'h0, 3'd0);

      // Release and confirm the pipeline resumes with the current instruction.
      @(negedge clk);
      rst        = 1'b0;
      instructor = 32'hFE11_2E23;
      sb.push_back('{"resume_after_rst", 64'hFFFF_FFFF_FFFF_FFFC, 3'd2});
      sample();

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #20000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
